// File: rtl/bist_pkg.sv
// Package: bist_pkg
// Session state encoding and timeout counter width shared by the BIST scheduler.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ASSERT,
    RUN,
    CHECK,
    RELEASE,
    GAP
  } state_t;

  localparam int TO_W = 8;

endpackage

// File: rtl/bist_session_sched_rr_arbiter.sv
// Module: rr_arbiter
// Combinational masked-priority round-robin: the lowest requester at or above
// ptr wins, otherwise the lowest requester overall (wrap-around).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] masked;

  // Keep only the requests at or above the pointer.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
  end

  // Lowest raw request first, then overridden by the lowest masked request if any.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bist_session_sched.sv
// Module: bist_session_sched
// Shares one BIST engine among N_REQ requesters: round-robin grant, START
// handshake, LFSR/MISR stepping, signature compare and timeout abort.
module bist_session_sched
  import bist_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int SIG_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*SIG_W-1:0] GOLDEN,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DONE,
  output logic                   PASS,
  output logic                   ERR,
  output logic                   BIST_START,
  input  logic                   BIST_INIT,
  input  logic                   BIST_RUNNING,
  input  logic                   BIST_FINISH,
  input  logic                   BIST_END,
  output logic                   LFSR_LOAD,
  output logic                   MISR_CLR,
  output logic                   LFSR_EN,
  output logic                   MISR_EN,
  input  logic [SIG_W-1:0]       SIG_IN
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] winner, winner_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic             rel_cnt, rel_cnt_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic [N_REQ-1:0] done_q, done_n;
  logic             pass_q, pass_n;
  logic             err_q, err_n;
  logic             start_q, start_n;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic [SIG_W-1:0] golden_sel;
  logic             sig_match;
  logic             timeout_hit;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req(REQ),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign golden_sel  = GOLDEN[int'(winner)*SIG_W +: SIG_W];
  assign sig_match   = (SIG_IN == golden_sel);
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT));

  // Seed/clear on the engine INIT pulse and step the datapath only while running.
  always_comb begin
    LFSR_LOAD = (state == ASSERT) && BIST_INIT;
    MISR_CLR  = (state == ASSERT) && BIST_INIT;
    LFSR_EN   = (state == RUN) && BIST_RUNNING;
    MISR_EN   = (state == RUN) && BIST_RUNNING;
  end

  // Session sequencing; every registered output is computed here for the next cycle.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    winner_n  = winner;
    to_cnt_n  = to_cnt;
    rel_cnt_n = rel_cnt;
    gnt_n     = gnt_q;
    done_n    = '0;
    pass_n    = pass_q;
    err_n     = err_q;
    case (state)
      IDLE: begin
        if (|REQ) state_n = ARB;
      end
      ARB: begin
        if (|REQ) begin
          gnt_n    = arb_gnt;
          winner_n = arb_idx;
          ptr_n    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          to_cnt_n = '0;
          state_n  = ASSERT;
        end else begin
          state_n = IDLE;
        end
      end
      ASSERT, RUN: begin
        if (!(&to_cnt)) to_cnt_n = to_cnt + TO_W'(1);
        if ((state == RUN) && BIST_FINISH) begin
          done_n  = gnt_q;
          pass_n  = sig_match;
          err_n   = 1'b0;
          state_n = CHECK;
        end else if (timeout_hit) begin
          done_n    = gnt_q;
          pass_n    = 1'b0;
          err_n     = 1'b1;
          rel_cnt_n = 1'b0;
          state_n   = RELEASE;
        end else if ((state == ASSERT) && BIST_INIT) begin
          state_n = RUN;
        end
      end
      CHECK: begin
        rel_cnt_n = 1'b0;
        state_n   = RELEASE;
      end
      RELEASE: begin
        rel_cnt_n = 1'b1;
        if (BIST_END || rel_cnt) begin
          gnt_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        state_n = (|REQ) ? ARB : IDLE;
      end
      default: state_n = IDLE;
    endcase
    start_n = (state_n == ASSERT) || (state_n == RUN);
  end

  // State and registered outputs; reset drops START and the grant immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      ptr     <= '0;
      winner  <= '0;
      to_cnt  <= '0;
      rel_cnt <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      winner  <= winner_n;
      to_cnt  <= to_cnt_n;
      rel_cnt <= rel_cnt_n;
      gnt_q   <= gnt_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      start_q <= start_n;
    end
  end

  assign GNT        = gnt_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR        = err_q;
  assign BIST_START = start_q;

endmodule

// File: tb/tb_bist_session_sched.sv
// Testbench: tb_bist_session_sched
// Behavioural BIST engine plus a session-level reference of the scheduler,
// compared against the DUT every cycle, with hand-computed anchor checks.
module tb_bist_session_sched;

  localparam int N       = 4;
  localparam int SW      = 16;
  localparam int TIMEOUT = 255;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  REQ;
  logic [N*SW-1:0] GOLDEN;
  logic [N-1:0]  GNT, DONE;
  logic          PASS, ERR, BIST_START;
  logic          BIST_INIT, BIST_RUNNING, BIST_FINISH, BIST_END;
  logic          LFSR_LOAD, MISR_CLR, LFSR_EN, MISR_EN;
  logic [SW-1:0] SIG_IN;

  int nChecks = 0;
  int nFails  = 0;

  // engine controls set by the main sequence
  int hang    = 0;
  int sigMode = 0;
  int runLen  = 90;

  // per-session counters kept by the compare process
  int runCnt  = 0;
  int lfsrCnt = 0;
  int loadCnt = 0;

  bist_session_sched #(.N_REQ(N), .SIG_W(SW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GOLDEN(GOLDEN),
    .GNT(GNT), .DONE(DONE), .PASS(PASS), .ERR(ERR), .BIST_START(BIST_START),
    .BIST_INIT(BIST_INIT), .BIST_RUNNING(BIST_RUNNING), .BIST_FINISH(BIST_FINISH),
    .BIST_END(BIST_END), .LFSR_LOAD(LFSR_LOAD), .MISR_CLR(MISR_CLR),
    .LFSR_EN(LFSR_EN), .MISR_EN(MISR_EN), .SIG_IN(SIG_IN)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req);
    @(posedge CLK);
    #2;
    REQ = req;
  endtask

  function automatic int onehotIdx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int rrPick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Engine model: INIT 9 cycles after START, runLen RUNNING cycles, FINISH, END after START low.
  initial begin
    int eng, cnt, rcnt, endWait, gi;
    eng = 0; cnt = 0; rcnt = 0; endWait = 0;
    BIST_INIT = 0; BIST_RUNNING = 0; BIST_FINISH = 0; BIST_END = 0; SIG_IN = '0;
    forever begin
      @(posedge CLK or posedge RESET);
      #1;
      BIST_INIT = 0; BIST_RUNNING = 0; BIST_FINISH = 0; BIST_END = 0;
      SIG_IN = SW'($urandom);
      if (RESET) begin
        eng = 0;
      end else begin
        if (!BIST_START && eng >= 1 && eng <= 3) eng = 0;
        case (eng)
          0: if (BIST_START) begin eng = 1; cnt = 1; end
          1: begin
            cnt++;
            if (cnt == 9) begin BIST_INIT = 1; eng = 2; rcnt = 0; end
          end
          2: begin
            BIST_RUNNING = 1;
            rcnt++;
            if (rcnt >= runLen) eng = 3;
          end
          3: if (hang == 0) begin
            gi = onehotIdx(GNT);
            if (gi < 0) gi = 0;
            BIST_FINISH = 1;
            if (sigMode == 0) SIG_IN = GOLDEN[gi*SW +: SW];
            else if (sigMode == 1) SIG_IN = GOLDEN[gi*SW +: SW] - SW'(1);
            else if ($urandom_range(0, 1) == 1) SIG_IN = GOLDEN[gi*SW +: SW];
            eng = 4;
          end
          4: if (!BIST_START) begin eng = 5; endWait = $urandom_range(0, 2); end
          5: begin
            if (endWait == 0) begin BIST_END = 1; eng = 0; end
            else endWait--;
          end
          default: eng = 0;
        endcase
      end
    end
  end

  // Reference model of the scheduler at session level, compared on every falling edge.
  initial begin
    logic [N-1:0] eGnt, eDone;
    logic eStart, ePass, eErr, expLoad, expEn, prevStart;
    int mPtr, mWin, mAge, mRel, lowRun;
    bit mArb, mCheck, mGap, mInit, hadSession;
    eGnt = '0; eDone = '0; eStart = 0; ePass = 0; eErr = 0; prevStart = 0;
    mPtr = 0; mWin = 0; mAge = -1; mRel = -1; lowRun = 0;
    mArb = 0; mCheck = 0; mGap = 0; mInit = 0; hadSession = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        eGnt = '0; eDone = '0; eStart = 0; ePass = 0; eErr = 0; prevStart = 0;
        mPtr = 0; mAge = -1; mRel = -1; lowRun = 0;
        mArb = 0; mCheck = 0; mGap = 0; mInit = 0; hadSession = 0;
        checkOutput("outputs during reset",
          {15'd0, GNT, DONE, PASS, ERR, BIST_START, LFSR_LOAD, MISR_CLR, LFSR_EN, MISR_EN}, 32'd0);
      end else begin
        checkOutput("GNT", GNT, eGnt);
        checkOutput("DONE", DONE, eDone);
        checkOutput("PASS", PASS, ePass);
        checkOutput("ERR", ERR, eErr);
        checkOutput("BIST_START", BIST_START, eStart);
        expLoad = (mAge >= 0 && !mInit) ? BIST_INIT : 1'b0;
        expEn   = (mAge >= 0 && mInit) ? BIST_RUNNING : 1'b0;
        checkOutput("LFSR_LOAD", LFSR_LOAD, expLoad);
        checkOutput("MISR_CLR", MISR_CLR, expLoad);
        checkOutput("LFSR_EN", LFSR_EN, expEn);
        checkOutput("MISR_EN", MISR_EN, expEn);
        runCnt  += int'(BIST_RUNNING);
        lfsrCnt += int'(LFSR_EN);
        loadCnt += int'(LFSR_LOAD);
        if (BIST_START && !prevStart) begin
          if (hadSession) checkOutput("START low time >= 2", 32'(lowRun >= 2), 32'd1);
          hadSession = 1;
          lowRun = 0;
        end else if (!BIST_START) begin
          lowRun++;
        end
        prevStart = BIST_START;

        // predict the next cycle from what happens in this one
        eDone = '0;
        if (mArb) begin
          mArb = 0;
          if (REQ != '0) begin
            mWin = rrPick(REQ, mPtr);
            mPtr = (mWin + 1) % N;
            eGnt = '0;
            eGnt[mWin] = 1'b1;
            eStart = 1;
            mAge = 0;
            mInit = 0;
          end
        end else if (mAge >= 0) begin
          if (mInit && BIST_FINISH) begin
            eDone = eGnt; ePass = (SIG_IN == GOLDEN[mWin*SW +: SW]); eErr = 0;
            eStart = 0; mAge = -1; mCheck = 1;
          end else if (mAge == TIMEOUT) begin
            eDone = eGnt; ePass = 0; eErr = 1; eStart = 0; mAge = -1; mRel = 0;
          end else begin
            if (BIST_INIT) mInit = 1;
            mAge++;
          end
        end else if (mCheck) begin
          mCheck = 0;
          mRel = 0;
        end else if (mRel >= 0) begin
          if (BIST_END || mRel == 1) begin mRel = -1; eGnt = '0; mGap = 1; end
          else mRel = 1;
        end else if (mGap) begin
          mGap = 0;
          mArb = (REQ != '0);
        end else if (REQ != '0) begin
          mArb = 1;
        end
      end
    end
  end

  task automatic waitDone(output logic [N-1:0] d, output logic p, output logic e);
    bit got;
    got = 0; d = '0; p = 0; e = 0;
    for (int k = 0; k < 700 && !got; k++) begin
      @(negedge CLK);
      if (DONE != '0) begin got = 1; d = DONE; p = PASS; e = ERR; end
    end
    checkOutput("DONE within bound", 32'(got), 32'd1);
  endtask

  task automatic waitRunning();
    bit got;
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      if (BIST_RUNNING) got = 1;
    end
    checkOutput("RUNNING within bound", 32'(got), 32'd1);
  endtask

  task automatic doReset();
    @(posedge CLK);
    #2 RESET = 1;
    repeat (3) @(posedge CLK);
    #2 RESET = 0;
  endtask

  // Directed sessions, boundary cases and a randomized tail.
  initial begin
    logic [N-1:0] d;
    logic p, e;
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    RESET = 1;
    REQ = '0;
    for (int k = 0; k < N; k++) GOLDEN[k*SW +: SW] = SW'($urandom);
    GOLDEN[15:0] = 16'hA5C3;
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("reset outputs",
      {15'd0, GNT, DONE, PASS, ERR, BIST_START, LFSR_LOAD, MISR_CLR, LFSR_EN, MISR_EN}, 32'd0);
    RESET = 0;

    $display("[TB] single requester session");
    runCnt = 0; lfsrCnt = 0; loadCnt = 0;
    applyStimulus(4'b0001);
    @(posedge CLK); #1;
    checkOutput("GNT after 1 cycle", GNT, 4'b0000);
    @(posedge CLK); #1;
    checkOutput("GNT after 2 cycles", GNT, 4'b0001);
    checkOutput("START after 2 cycles", BIST_START, 1'b1);
    waitDone(d, p, e);
    checkOutput("DONE first session", d, 4'b0001);
    checkOutput("PASS on golden match", p, 1'b1);
    checkOutput("ERR on golden match", e, 1'b0);
    checkOutput("RUNNING cycles", runCnt, 32'd90);
    checkOutput("LFSR_EN cycles", lfsrCnt, 32'd90);
    checkOutput("LFSR_LOAD pulses", loadCnt, 32'd1);
    sigMode = 1;
    waitDone(d, p, e);
    checkOutput("PASS on A5C2", p, 1'b0);
    checkOutput("DONE second session", d, 4'b0001);
    applyStimulus(4'b0000);
    repeat (10) @(posedge CLK);

    $display("[TB] round robin with all requesters");
    doReset();
    applyStimulus(4'b1111);
    for (int i = 0; i < 8; i++) begin
      sigMode = $urandom_range(0, 2);
      runLen = $urandom_range(20, 100);
      waitDone(d, p, e);
      checkOutput($sformatf("rr order %0d", i), 32'(onehotIdx(d)), 32'(order[i]));
    end
    applyStimulus(4'b0000);
    repeat (10) @(posedge CLK);

    $display("[TB] timeout and boundary");
    hang = 1; runLen = 90; sigMode = 0;
    applyStimulus(4'b0001);
    waitDone(d, p, e);
    checkOutput("timeout DONE", d, 4'b0001);
    checkOutput("timeout ERR", e, 1'b1);
    checkOutput("timeout PASS", p, 1'b0);
    hang = 0;
    applyStimulus(4'b0100);
    waitDone(d, p, e);
    checkOutput("after timeout DONE", d, 4'b0100);
    checkOutput("after timeout ERR", e, 1'b0);
    checkOutput("after timeout PASS", p, 1'b1);
    runLen = 246;
    applyStimulus(4'b0001);
    waitDone(d, p, e);
    checkOutput("finish at limit ERR", e, 1'b0);
    checkOutput("finish at limit PASS", p, 1'b1);
    runLen = 247;
    waitDone(d, p, e);
    checkOutput("finish past limit ERR", e, 1'b1);
    checkOutput("finish past limit PASS", p, 1'b0);
    applyStimulus(4'b0000);
    runLen = 90;
    repeat (10) @(posedge CLK);

    $display("[TB] request drop and reset mid-session");
    applyStimulus(4'b0100);
    waitRunning();
    applyStimulus(4'b0000);
    waitDone(d, p, e);
    checkOutput("dropped REQ DONE", d, 4'b0100);
    repeat (10) @(posedge CLK);
    applyStimulus(4'b0010);
    waitRunning();
    @(posedge CLK); #1;
    checkOutput("START before reset", BIST_START, 1'b1);
    #1 RESET = 1;
    #1;
    checkOutput("START on reset", BIST_START, 1'b0);
    checkOutput("GNT on reset", GNT, 4'b0000);
    repeat (2) @(posedge CLK);
    #2 RESET = 0;
    applyStimulus(4'b0000);
    repeat (10) @(posedge CLK);

    $display("[TB] randomized sessions");
    for (int i = 0; i < 10; i++) begin
      hang = ($urandom_range(0, 7) == 0) ? 1 : 0;
      sigMode = $urandom_range(0, 2);
      runLen = $urandom_range(20, 120);
      applyStimulus(N'($urandom_range(1, 15)));
      waitDone(d, p, e);
    end
    hang = 0;
    applyStimulus(4'b0000);
    repeat (20) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
